// File: rtl/gemm_b_tile_loader_pkg.sv
// gemm_b_tile_loader_pkg: shared types and constants
// for the GEMM weight-tile loader.
package gemm_b_tile_loader_pkg;

  localparam int DATA_W         = 16;
  localparam int TILE_K_DEFAULT = 16;

  typedef enum logic [1:0] {
    TL_IDLE,
    TL_RUN,
    TL_DONE
  } tile_ld_state_t;

  // Index width that stays legal for a depth of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// gemm_tile_addr_gen: tile geometry latch and issue
// pointer with row-jump skip and row address.
module gemm_tile_addr_gen
  import gemm_b_tile_loader_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int TILE_K = TILE_K_DEFAULT,
  parameter int ADDR_W = 24,
  parameter int DIM_W  = 16,
  parameter int KE_W   = $clog2(TILE_K + 1),
  parameter int NE_W   = $clog2(COLS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [DIM_W-1:0]  i_k_total,
  input  logic [DIM_W-1:0]  i_n_total,
  input  logic [DIM_W-1:0]  i_k_base,
  input  logic [DIM_W-1:0]  i_n_base,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [KE_W-1:0]   o_k_eff,
  output logic [NE_W-1:0]   o_n_eff
);

  localparam logic signed [DIM_W:0] TK_S =
    (DIM_W+1)'(TILE_K);
  localparam logic signed [DIM_W:0] TN_S =
    (DIM_W+1)'(COLS);

  logic signed [DIM_W:0] w_k_diff;
  logic signed [DIM_W:0] w_n_diff;
  logic [KE_W-1:0]       w_k_eff;
  logic [NE_W-1:0]       w_n_eff;
  logic [ADDR_W-1:0]     w_row0;

  logic [KE_W-1:0]       r_kk;
  logic [NE_W-1:0]       r_col;
  logic [KE_W-1:0]       r_k_eff;
  logic [NE_W-1:0]       r_n_eff;
  logic [DIM_W-1:0]      r_n_total;
  logic [ADDR_W-1:0]     r_row_addr;

  assign w_k_diff = $signed({1'b0, i_k_total})
                  - $signed({1'b0, i_k_base});
  assign w_n_diff = $signed({1'b0, i_n_total})
                  - $signed({1'b0, i_n_base});

  // Clamp remaining rows/cols of the layer to the tile size.
  always_comb begin
    w_k_eff = w_k_diff[KE_W-1:0];
    w_n_eff = w_n_diff[NE_W-1:0];
    if (w_k_diff[DIM_W] || w_k_diff == '0)
      w_k_eff = '0;
    else if (w_k_diff > TK_S)
      w_k_eff = KE_W'(TILE_K);
    if (w_n_diff[DIM_W] || w_n_diff == '0)
      w_n_eff = '0;
    else if (w_n_diff > TN_S)
      w_n_eff = NE_W'(COLS);
  end

  // The only multiply runs once at load; later rows add n_total.
  assign w_row0 = i_base_addr
                + ADDR_W'(i_k_base) * ADDR_W'(i_n_total)
                + ADDR_W'(i_n_base);

  // The pointer only ever rests on valid positions: the last
  // valid column jumps straight to the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kk       <= '0;
      r_col      <= '0;
      r_k_eff    <= '0;
      r_n_eff    <= '0;
      r_n_total  <= '0;
      r_row_addr <= '0;
    end else if (i_load) begin
      r_kk       <= '0;
      r_col      <= '0;
      r_k_eff    <= w_k_eff;
      r_n_eff    <= w_n_eff;
      r_n_total  <= i_n_total;
      r_row_addr <= w_row0;
    end else if (i_adv) begin
      if (NE_W'(r_col + 1'b1) == r_n_eff) begin
        r_col      <= '0;
        r_kk       <= r_kk + 1'b1;
        r_row_addr <= r_row_addr + ADDR_W'(r_n_total);
      end else begin
        r_col      <= r_col + 1'b1;
      end
    end
  end

  assign o_valid = (r_kk < r_k_eff) && (r_n_eff != '0);
  assign o_addr  = r_row_addr + ADDR_W'(r_col);
  assign o_k_eff = r_k_eff;
  assign o_n_eff = r_n_eff;

endmodule

// File: rtl/gemm_b_tile_loader.sv
// gemm_b_tile_loader: fetches one TILE_K x COLS weight tile
// into a double-buffered B buffer, zero-padding the edges.
module gemm_b_tile_loader
  import gemm_b_tile_loader_pkg::*;
#(
  parameter int COLS            = 16,
  parameter int TILE_K          = TILE_K_DEFAULT,
  parameter int DATA_W_P        = DATA_W,
  parameter int ADDR_W          = 24,
  parameter int DIM_W           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic [DIM_W-1:0]           k_total,
  input  logic [DIM_W-1:0]           n_total,
  input  logic [DIM_W-1:0]           tile_k_base,
  input  logic [DIM_W-1:0]           tile_n_base,
  input  logic [ADDR_W-1:0]          w_base_addr,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       rsp_valid,
  input  logic [DATA_W_P-1:0]        rsp_data,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [$clog2(TILE_K)-1:0]  wr_k,
  output logic [$clog2(COLS)-1:0]    wr_col,
  output logic signed [DATA_W_P-1:0] wr_data,
  output logic                       bank_sel
);

  localparam int KW   = $clog2(TILE_K);
  localparam int CW   = $clog2(COLS);
  localparam int KE_W = $clog2(TILE_K + 1);
  localparam int NE_W = $clog2(COLS + 1);
  localparam int OC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SI_W = idx_w(MAX_OUTSTANDING);

  tile_ld_state_t      r_state;
  logic                r_done;
  logic                r_busy;
  logic                r_bank_sel;
  logic                r_wr_bank;
  logic [KW-1:0]       r_wr_k;
  logic [CW-1:0]       r_wr_col;
  logic                r_wr_end;
  logic [OC_W-1:0]     r_out;
  logic [DATA_W_P-1:0] r_skid_mem [MAX_OUTSTANDING];
  logic [SI_W-1:0]     r_skid_rd;
  logic [SI_W-1:0]     r_skid_wr;
  logic [OC_W-1:0]     r_skid_cnt;

  logic                w_run;
  logic                w_load;
  logic                w_iss_valid;
  logic [ADDR_W-1:0]   w_iss_addr;
  logic [KE_W-1:0]     w_k_eff;
  logic [NE_W-1:0]     w_n_eff;
  logic [OC_W:0]       w_inflight;
  logic                w_room;
  logic                w_req_hs;
  logic                w_rsp;
  logic                w_pos_valid;
  logic                w_held;
  logic                w_wr_fire;
  logic                w_pop;
  logic                w_push;
  logic                w_last;
  logic [OC_W-1:0]     w_out_nxt;
  logic [DATA_W_P-1:0] w_wr_data;

  assign w_run  = (r_state == TL_RUN);
  assign w_load = (r_state == TL_IDLE) && start;

  gemm_tile_addr_gen #(
    .COLS   (COLS),
    .TILE_K (TILE_K),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .KE_W   (KE_W),
    .NE_W   (NE_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_adv       (w_req_hs),
    .i_k_total   (k_total),
    .i_n_total   (n_total),
    .i_k_base    (tile_k_base),
    .i_n_base    (tile_n_base),
    .i_base_addr (w_base_addr),
    .o_valid     (w_iss_valid),
    .o_addr      (w_iss_addr),
    .o_k_eff     (w_k_eff),
    .o_n_eff     (w_n_eff)
  );

  // Held responses count against the read budget so the
  // holding buffer can never overflow.
  assign w_inflight = {1'b0, r_out} + {1'b0, r_skid_cnt};
  assign w_room     = w_inflight
                    < (OC_W+1)'(MAX_OUTSTANDING);

  assign req_valid = w_run && w_iss_valid && w_room;
  assign req_addr  = w_iss_addr;
  assign w_req_hs  = req_valid && req_ready;
  assign w_rsp     = rsp_valid && w_run;

  assign w_pos_valid = (KE_W'(r_wr_k) < w_k_eff)
                    && (NE_W'(r_wr_col) < w_n_eff);
  assign w_held      = (r_skid_cnt != '0);
  assign w_wr_fire   = w_run && !r_wr_end
                    && (!w_pos_valid || w_held || w_rsp);
  assign w_pop       = w_run && !r_wr_end
                    && w_pos_valid && w_held;
  assign w_push      = w_rsp
                    && !(w_pos_valid && !w_held && !r_wr_end);
  assign w_last      = (r_wr_k == KW'(TILE_K - 1))
                    && (r_wr_col == CW'(COLS - 1));

  // Pads write zero; data comes from the oldest held
  // response first so ordering stays ascending.
  always_comb begin
    w_wr_data = '0;
    if (w_pos_valid)
      w_wr_data = w_held ? r_skid_mem[r_skid_rd] : rsp_data;
  end

  // Reads issued but not yet returned.
  always_comb begin
    w_out_nxt = r_out;
    if (w_req_hs && !w_rsp)
      w_out_nxt = r_out + 1'b1;
    else if (!w_req_hs && w_rsp)
      w_out_nxt = r_out - 1'b1;
  end

  // Outstanding read counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_out_nxt;
  end

  // FIFO for responses that arrive while the writer is on pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_skid_mem[i] <= '0;
      r_skid_rd  <= '0;
      r_skid_wr  <= '0;
      r_skid_cnt <= '0;
    end else if (w_load) begin
      r_skid_rd  <= '0;
      r_skid_wr  <= '0;
      r_skid_cnt <= '0;
    end else begin
      if (w_push) begin
        r_skid_mem[r_skid_wr] <= rsp_data;
        r_skid_wr <= (r_skid_wr == SI_W'(MAX_OUTSTANDING - 1))
                   ? '0 : r_skid_wr + 1'b1;
      end
      if (w_pop)
        r_skid_rd <= (r_skid_rd == SI_W'(MAX_OUTSTANDING - 1))
                   ? '0 : r_skid_rd + 1'b1;
      if (w_push && !w_pop)
        r_skid_cnt <= r_skid_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_skid_cnt <= r_skid_cnt - 1'b1;
    end
  end

  // Write pointer walks every tile position once, ascending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_k   <= '0;
      r_wr_col <= '0;
      r_wr_end <= 1'b0;
    end else if (w_load) begin
      r_wr_k   <= '0;
      r_wr_col <= '0;
      r_wr_end <= 1'b0;
    end else if (w_wr_fire) begin
      if (w_last) begin
        r_wr_k   <= '0;
        r_wr_col <= '0;
        r_wr_end <= 1'b1;
      end else if (r_wr_col == CW'(COLS - 1)) begin
        r_wr_col <= '0;
        r_wr_k   <= r_wr_k + 1'b1;
      end else begin
        r_wr_col <= r_wr_col + 1'b1;
      end
    end
  end

  // Control FSM with registered busy/done/bank outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TL_IDLE;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_bank_sel <= 1'b0;
      r_wr_bank  <= 1'b1;
    end else begin
      unique case (r_state)
        TL_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= TL_RUN;
            r_busy  <= 1'b1;
          end
        end
        TL_RUN: begin
          if ((r_wr_end || (w_wr_fire && w_last))
              && w_out_nxt == '0) begin
            r_state <= TL_DONE;
            r_done  <= 1'b1;
          end
        end
        TL_DONE: begin
          r_state    <= TL_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_bank_sel <= r_wr_bank;
          r_wr_bank  <= ~r_wr_bank;
        end
        default: r_state <= TL_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bank_sel = r_bank_sel;
  assign wr_bank  = r_wr_bank;
  assign wr_en    = w_wr_fire;
  assign wr_k     = r_wr_k;
  assign wr_col   = r_wr_col;
  assign wr_data  = $signed(w_wr_data);

endmodule

// File: tb/tb_gemm_b_tile_loader.sv
// tb_gemm_b_tile_loader: randomized bench with a
// tile-level reference model and an in-order memory model.
module tb_gemm_b_tile_loader;

  localparam int COLS   = 16;
  localparam int TILE_K = 16;
  localparam int TOTAL  = COLS * TILE_K;
  localparam int ADDR_W = 24;
  localparam int DIM_W  = 16;
  localparam int DW     = 16;
  localparam int MAXO   = 4;
  localparam int BUDGET = 4000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [DIM_W-1:0]  k_total;
  logic [DIM_W-1:0]  n_total;
  logic [DIM_W-1:0]  tile_k_base;
  logic [DIM_W-1:0]  tile_n_base;
  logic [ADDR_W-1:0] w_base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              wr_en;
  logic              wr_bank;
  logic [3:0]        wr_k;
  logic [3:0]        wr_col;
  logic [DW-1:0]     wr_data;
  logic              bank_sel;

  always #5 clk = ~clk;

  gemm_b_tile_loader #(
    .COLS            (COLS),
    .TILE_K          (TILE_K),
    .DATA_W_P        (DW),
    .ADDR_W          (ADDR_W),
    .DIM_W           (DIM_W),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .k_total     (k_total),
    .n_total     (n_total),
    .tile_k_base (tile_k_base),
    .tile_n_base (tile_n_base),
    .w_base_addr (w_base_addr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_k        (wr_k),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .bank_sel    (bank_sel)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  rsp_t mem_q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   inflight;
  int   max_infl;
  logic exp_wr_bank;
  logic exp_bank_sel;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Memory holds mem[a] = a[15:0]; fixed latency keeps order.
  task automatic drive_mem();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_t e;
      e = mem_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = e.data;
      inflight--;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 16'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    mem_q.delete();
    inflight  = 0;
    start     = 1'b0;
    rsp_valid = 1'b0;
    @(negedge clk);
    cyc++;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_wr_bank", wr_bank, 1);
    rst_n = 1'b1;
    exp_wr_bank  = 1'b1;
    exp_bank_sel = 1'b0;
  endtask

  task automatic run_tile(input int kt, input int nt,
                          input int kb, input int nb,
                          input int base, input int rdy_pct,
                          input int lat, input int exp_done,
                          input int rst_at);
    int          ke, ne, nreq, wr_cnt, done_c, n_exp;
    int          exp_req[$];
    logic [15:0] exp_d [TOTAL];
    logic [23:0] a;
    bit          got_done;
    ke = kt - kb;
    ke = (ke < 0) ? 0 : (ke > TILE_K) ? TILE_K : ke;
    ne = nt - nb;
    ne = (ne < 0) ? 0 : (ne > COLS) ? COLS : ne;
    for (int kk = 0; kk < TILE_K; kk++)
      for (int c = 0; c < COLS; c++) begin
        if (kk < ke && c < ne) begin
          a = 24'(longint'(base)
                + longint'(kb + kk) * longint'(nt)
                + longint'(nb + c));
          exp_req.push_back(int'(a));
          exp_d[kk*COLS + c] = a[15:0];
        end else begin
          exp_d[kk*COLS + c] = '0;
        end
      end
    n_exp    = exp_req.size();
    nreq     = 0;
    wr_cnt   = 0;
    done_c   = -1;
    got_done = 0;
    max_infl = 0;
    for (int c = 0; c < BUDGET && !got_done; c++) begin
      @(negedge clk);
      cyc++;
      if (c == 0) begin
        k_total     = 16'(kt);
        n_total     = 16'(nt);
        tile_k_base = 16'(kb);
        tile_n_base = 16'(nb);
        w_base_addr = 24'(base);
        start       = 1'b1;
      end else begin
        start       = ($urandom_range(0, 7) == 0);
        k_total     = 16'($urandom);
        n_total     = 16'($urandom);
        tile_k_base = 16'($urandom);
        tile_n_base = 16'($urandom);
        w_base_addr = 24'($urandom);
      end
      req_ready = ($urandom_range(0, 99) < rdy_pct);
      drive_mem();
      #1;
      if (c == 1) check("busy_rise", busy, 1);
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0)
          check("req_over", nreq + 1, n_exp);
        else
          check("req_addr", req_addr, exp_req.pop_front());
        nreq++;
        mem_q.push_back('{cyc + lat, 16'(req_addr)});
        inflight++;
        if (inflight > max_infl) max_infl = inflight;
      end
      if (wr_en) begin
        if (wr_cnt < TOTAL) begin
          check("wr_pos", {wr_k, wr_col}, wr_cnt);
          check("wr_data", wr_data, exp_d[wr_cnt]);
          if (wr_cnt == 0)
            check("wr_bank", wr_bank, exp_wr_bank);
        end
        wr_cnt++;
      end
      if (rst_at >= 0 && wr_cnt == rst_at) begin
        apply_reset();
        return;
      end
      if (done) begin
        got_done = 1;
        done_c   = c;
      end
    end
    if (!got_done) check("done_timeout", done, 1);
    check("req_count", nreq, n_exp);
    check("wr_count", wr_cnt, TOTAL);
    check("outstanding_le_max", max_infl <= MAXO, 1);
    if (exp_done >= 0) check("done_cycle", done_c, exp_done);
    exp_bank_sel = exp_wr_bank;
    exp_wr_bank  = ~exp_wr_bank;
    @(negedge clk);
    cyc++;
    start     = 1'b0;
    req_ready = 1'b0;
    drive_mem();
    #1;
    check("bank_sel", bank_sel, exp_bank_sel);
    check("wr_bank_next", wr_bank, exp_wr_bank);
    check("busy_fall", busy, 0);
    check("done_pulse", done, 0);
    check("no_extra_wr", wr_en, 0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    inflight     = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    k_total      = '0;
    n_total      = '0;
    tile_k_base  = '0;
    tile_n_base  = '0;
    w_base_addr  = '0;
    exp_wr_bank  = 1'b1;
    exp_bank_sel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_req_valid", req_valid, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_bank_sel", bank_sel, 0);
    check("reset_wr_bank", wr_bank, 1);
    rst_n = 1'b1;

    run_tile(147, 64, 0,   0,  0,     100, 1, 258, -1);
    run_tile(147, 64, 144, 0,  0,     100, 1, -1,  -1);
    run_tile(147, 40, 0,   32, 'h100, 100, 1, -1,  -1);
    run_tile(147, 64, 16,  16, 0,     30,  3, -1,  -1);
    run_tile(147, 64, 160, 0,  0,     100, 1, -1,  -1);
    run_tile(147, 64, 160, 0,  0,     60,  2, -1,  -1);
    run_tile(147, 64, 0,   0,  0,     100, 1, -1,  100);
    run_tile(147, 64, 16,  16, 0,     70,  2, -1,  -1);
    for (int i = 0; i < 6; i++)
      run_tile($urandom_range(1, 60), $urandom_range(1, 60),
               $urandom_range(0, 64), $urandom_range(0, 64),
               int'($urandom_range(0, 24'hFFFFFF)),
               $urandom_range(20, 100), $urandom_range(1, 4),
               -1, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
